pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core (IF, DC, ALU, MEM, WB). It works alongside the operand-forwarding unit.
- Covers the hazards forwarding cannot resolve: load-use, taken-branch redirect and data-memory wait states. For each it generates per-stage stall, bubble and flush controls.
- Detects data-memory timeout and halts the pipeline with a sticky error.

Parameters:
- REG_ADDR_W, 5, register address width (matches `RegAddrSize`).
- MEM_TIMEOUT, 64, max consecutive cycles waiting on mem_ready before error; legal range 2..255.
- CNT_W, 8, width of the wait counter; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-low.
- dc_rs1  in  REG_ADDR_W  DC-stage source 1 address.
- dc_rs2  in  REG_ADDR_W  DC-stage source 2 address.
- dc_rs1_used  in  1  DC instruction reads rs1.
- dc_rs2_used  in  1  DC instruction reads rs2.
- alu_rd  in  REG_ADDR_W  ALU-stage destination.
- alu_is_load  in  1  ALU-stage instruction is a load.
- alu_br_taken  in  1  ALU stage resolved a taken branch or jump.
- mem_req  in  1  MEM stage has an active data-memory access.
- mem_ready  in  1  data memory completes the access this cycle.
- stall_pc  out  1  hold PC.
- stall_if_dc  out  1  hold IF/DC register.
- stall_dc_alu  out  1  hold DC/ALU register.
- stall_alu_mem  out  1  hold ALU/MEM register.
- bubble_dc_alu  out  1  load NOP into DC/ALU.
- flush_if_dc  out  1  clear IF/DC to NOP.
- pc_redirect  out  1  PC takes the branch target.
- halted  out  1  controller in HALT.
- mem_err  out  1  sticky memory-timeout flag.

Behaviour:
- Reset: clk only; synchronous; rst==0 at posedge.
  - state<=RUN, wait_cnt<=0, mem_err<=0.
  - All outputs 0 during and after reset until a hazard occurs.
- States: RUN, MEM_WAIT, HALT (2-bit, registered). Outputs are Mealy: combinational from state plus inputs in the same cycle; zero latency.
- Hazard terms:
  - mem_stall = mem_req & ~mem_ready.
  - load_use = alu_is_load & (alu_rd!=0) & ((dc_rs1_used & dc_rs1==alu_rd) | (dc_rs2_used & dc_rs2==alu_rd)).
  - x0 never causes a hazard.
- Priority (highest first): HALT > mem_stall > alu_br_taken > load_use.
- RUN:
  - mem_stall: all four stall_* =1, bubble/flush/redirect =0. Next state MEM_WAIT, wait_cnt<=1.
  - else alu_br_taken: pc_redirect=1, flush_if_dc=1, bubble_dc_alu=1, stalls=0. Any simultaneous load_use is ignored because the DC instruction is squashed.
  - else load_use: stall_pc=1, stall_if_dc=1, bubble_dc_alu=1. Exactly one bubble per load. The next cycle the load is in MEM and forwarding from MEM/WB resolves the dependency.
  - else all outputs 0.
- MEM_WAIT:
  - mem_stall still 1:
    - all stall_* =1; wait_cnt increments.
    - If wait_cnt==MEM_TIMEOUT-1 on this cycle, next state HALT and mem_err<=1.
  - mem_ready=1 or mem_req dropped: stalls released in this same cycle. Branch and load-use are evaluated as in RUN this cycle. Next state RUN, wait_cnt<=0.
  - alu_br_taken or load_use arriving during the wait are not acted on until release (the frozen ALU instruction persists).
- HALT: all stall_* =1, bubble/flush/redirect =0, halted=1. Exit only by reset.
- wait_cnt saturates; it never wraps.
- Reset mid-wait or in HALT returns to RUN with mem_err cleared.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_load_stalls[31:0], perf_mem_stalls[31:0] and perf_flushes[31:0], all reset to 0.
  - perf_load_stalls +1 per cycle with load_use acted on.
  - perf_mem_stalls +1 per cycle with all stall_* =1 outside HALT.
  - perf_flushes +1 per pc_redirect.
  - All three wrap at 2^32.
- Undefined: ports and counters are absent. Core behaviour is identical.

Decomposition:
- Shared define file:
  - state encodings `HzStateRun`/`HzStateMemWait`/`HzStateHalt` and `HzStateBus`.
  - reuse of `RegAddrSize` and `ZeroReg` (x0).
- One natural sub-module: hazard_load_use_det, a pure combinational load_use compare. Instantiated once; unit-tested separately.

Test Plan:
- Load x5 in ALU (alu_is_load=1, alu_rd=5), DC rs2=5 used -> that cycle stall_pc=stall_if_dc=bubble_dc_alu=1. Next cycle (load moved on) all 0.
- Load to x0 with DC rs1=0 used -> no stall, all outputs 0.
- alu_br_taken=1 together with load_use=1 -> pc_redirect=flush_if_dc=bubble_dc_alu=1, stall_pc=0.
- mem_req=1, mem_ready=0 for 3 cycles, then ready -> stall_* =1 for 3 cycles. Release on the ready cycle; state returns to RUN; wait_cnt=0.
- MEM_TIMEOUT=4, mem_ready held 0 -> stalls for 4 cycles, then halted=1 and mem_err=1 persist. rst=0 for one posedge -> all cleared.
- HAZARD_PERF_CNT_EN defined: 2 load-use events, 1 branch and a 3-cycle memory wait -> counters read 2, 3, 1.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: register-address constants and hazard controller state encoding.
package pipe_hazard_ctrl_pkg;
  localparam int RegAddrSize = 5;
  localparam logic [RegAddrSize-1:0] ZeroReg = '0;
  localparam int HzStateBus = 2;
  typedef enum logic [HzStateBus-1:0] {
    HzStateRun     = 2'd0,
    HzStateMemWait = 2'd1,
    HzStateHalt    = 2'd2
  } hz_state_e;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard inputs from the pipeline and per-stage control outputs.
interface pipe_hazard_ctrl_if
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = RegAddrSize
);
  logic [REG_ADDR_W-1:0] dc_rs1, dc_rs2, alu_rd;
  logic dc_rs1_used, dc_rs2_used, alu_is_load, alu_br_taken, mem_req, mem_ready;
  logic stall_pc, stall_if_dc, stall_dc_alu, stall_alu_mem;
  logic bubble_dc_alu, flush_if_dc, pc_redirect, halted, mem_err;
  modport master (
    output dc_rs1, dc_rs2, dc_rs1_used, dc_rs2_used, alu_rd, alu_is_load, alu_br_taken,
           mem_req, mem_ready,
    input  stall_pc, stall_if_dc, stall_dc_alu, stall_alu_mem, bubble_dc_alu, flush_if_dc,
           pc_redirect, halted, mem_err
  );
  modport slave (
    input  dc_rs1, dc_rs2, dc_rs1_used, dc_rs2_used, alu_rd, alu_is_load, alu_br_taken,
           mem_req, mem_ready,
    output stall_pc, stall_if_dc, stall_dc_alu, stall_alu_mem, bubble_dc_alu, flush_if_dc,
           pc_redirect, halted, mem_err
  );
endinterface

// File: rtl/pipe_hazard_ctrl_load_use_det.sv
// hazard_load_use_det: flags a DC-stage read of a register still being loaded in ALU (x0 exempt).
module hazard_load_use_det
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = RegAddrSize
) (
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic                  is_load,
  output logic                  load_use
);
  assign load_use = is_load && (rd != REG_ADDR_W'(ZeroReg)) &&
                    ((rs1_used && rs1 == rd) || (rs2_used && rs2 == rd));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use / branch / mem-wait stall, bubble and flush control with timeout halt.
// Optional HAZARD_PERF_CNT_EN adds load-stall, mem-stall and flush event counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = RegAddrSize,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 8
) (
  input logic clk,
  input logic rst,
  pipe_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_load_stalls,
  output logic [31:0] perf_mem_stalls,
  output logic [31:0] perf_flushes
`endif
);
  hz_state_e state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, cnt_nxt;
  logic err, err_nxt, load_use, mem_stall, in_halt, hold, br, lu;
  hazard_load_use_det #(.REG_ADDR_W(REG_ADDR_W)) u_det (
    .rs1(hz.dc_rs1), .rs2(hz.dc_rs2), .rd(hz.alu_rd),
    .rs1_used(hz.dc_rs1_used), .rs2_used(hz.dc_rs2_used),
    .is_load(hz.alu_is_load), .load_use(load_use)
  );
  assign mem_stall = hz.mem_req & ~hz.mem_ready;
  assign in_halt   = state == HzStateHalt;
  // a frozen pipeline defers branch and load-use until the memory releases it
  assign hold = in_halt | mem_stall;
  assign br   = ~hold & hz.alu_br_taken;
  assign lu   = ~hold & ~hz.alu_br_taken & load_use;
  assign hz.stall_pc      = hold | lu;
  assign hz.stall_if_dc   = hold | lu;
  assign hz.stall_dc_alu  = hold;
  assign hz.stall_alu_mem = hold;
  assign hz.bubble_dc_alu = br | lu;
  assign hz.flush_if_dc   = br;
  assign hz.pc_redirect   = br;
  assign hz.halted        = in_halt;
  assign hz.mem_err       = err;
  always_comb begin
    state_nxt = HzStateRun;
    cnt_nxt   = '0;
    err_nxt   = err;
    if (in_halt) begin
      state_nxt = HzStateHalt;
      cnt_nxt   = wait_cnt;
    end else if (mem_stall) begin
      state_nxt = (state == HzStateMemWait && wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) ? HzStateHalt : HzStateMemWait;
      err_nxt   = err | (state_nxt == HzStateHalt);
      cnt_nxt   = (state == HzStateRun) ? CNT_W'(1) : wait_cnt + CNT_W'(wait_cnt != '1);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= HzStateRun;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= cnt_nxt;
      err      <= err_nxt;
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_load_stalls <= '0;
      perf_mem_stalls  <= '0;
      perf_flushes     <= '0;
    end else begin
      perf_load_stalls <= perf_load_stalls + 32'(lu);
      perf_mem_stalls  <= perf_mem_stalls + 32'(mem_stall & ~in_halt);
      perf_flushes     <= perf_flushes + 32'(br);
    end
  end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random checks of pipe_hazard_ctrl against a cycle model.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;
  localparam int T = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;
  int m_wait;
  bit m_halt, m_err;
  pipe_hazard_ctrl_if hz ();
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_load_stalls, perf_mem_stalls, perf_flushes;
  logic [31:0] m_pl, m_pm, m_pf;
`endif
  pipe_hazard_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .hz(hz)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_load_stalls(perf_load_stalls), .perf_mem_stalls(perf_mem_stalls), .perf_flushes(perf_flushes)
`endif
  );
  always #5 clk = ~clk;

  function automatic logic spec_load_use();
    return hz.alu_is_load && hz.alu_rd != 0 &&
           ((hz.dc_rs1_used && hz.dc_rs1 == hz.alu_rd) || (hz.dc_rs2_used && hz.dc_rs2 == hz.alu_rd));
  endfunction

  // {stall_pc, stall_if_dc, stall_dc_alu, stall_alu_mem, bubble, flush, redirect, halted, mem_err}
  function automatic logic [8:0] expected();
    logic frz, b, l;
    frz = m_halt || (hz.mem_req && !hz.mem_ready);
    b = !frz && hz.alu_br_taken;
    l = !frz && !hz.alu_br_taken && spec_load_use();
    return {frz || l, frz || l, frz, frz, b || l, b, b, m_halt, m_err};
  endfunction

  function automatic logic [8:0] actual();
    return {hz.stall_pc, hz.stall_if_dc, hz.stall_dc_alu, hz.stall_alu_mem, hz.bubble_dc_alu,
            hz.flush_if_dc, hz.pc_redirect, hz.halted, hz.mem_err};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  always @(posedge clk) begin
    logic [8:0] e;
    e = expected();
    if (!rst) begin
      m_wait <= 0;
      m_halt <= 1'b0;
      m_err  <= 1'b0;
`ifdef HAZARD_PERF_CNT_EN
      m_pl <= '0;
      m_pm <= '0;
      m_pf <= '0;
`endif
    end else begin
`ifdef HAZARD_PERF_CNT_EN
      m_pl <= m_pl + 32'(e[8] && !e[6]);
      m_pm <= m_pm + 32'(e[6] && !e[1]);
      m_pf <= m_pf + 32'(e[2]);
`endif
      if (!m_halt) begin
        if (hz.mem_req && !hz.mem_ready) begin
          m_wait <= m_wait + 1;
          if (m_wait + 1 == T) begin
            m_halt <= 1'b1;
            m_err  <= 1'b1;
          end
        end else m_wait <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cycle_outputs", 32'(actual()), 32'(expected()));
`ifdef HAZARD_PERF_CNT_EN
      chk("perf_load_stalls", perf_load_stalls, m_pl);
      chk("perf_mem_stalls", perf_mem_stalls, m_pm);
      chk("perf_flushes", perf_flushes, m_pf);
`endif
    end
  end

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic u1, input logic u2, input logic ld, input logic br,
                        input logic req, input logic rdy);
    hz.dc_rs1 = rs1; hz.dc_rs2 = rs2; hz.alu_rd = rd;
    hz.dc_rs1_used = u1; hz.dc_rs2_used = u2; hz.alu_is_load = ld;
    hz.alu_br_taken = br; hz.mem_req = req; hz.mem_ready = rdy;
  endtask

  task automatic lit(input string name, input logic [8:0] exp);
    @(negedge clk);
    chk(name, 32'(actual()), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  localparam logic [8:0] Idle = 9'b000000000;
  localparam logic [8:0] LoadStall = 9'b110010000;
  localparam logic [8:0] Branch = 9'b000011100;
  localparam logic [8:0] MemStall = 9'b111100000;
  localparam logic [8:0] Halted = 9'b111100011;

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    cmp_en = 1'b1;
    lit("in_reset", Idle);
    rst = 1'b1;
    lit("after_reset", Idle);
    set_in(1, 5, 5, 1, 1, 1, 0, 0, 0);
    lit("load_use_rs2", LoadStall);
    set_in(1, 5, 5, 1, 1, 0, 0, 0, 0);
    lit("load_moved_on", Idle);
    set_in(0, 3, 0, 1, 0, 1, 0, 0, 0);
    lit("load_x0", Idle);
    set_in(7, 5, 5, 0, 1, 1, 1, 0, 0);
    lit("branch_over_load_use", Branch);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (3) lit("mem_wait", MemStall);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
    lit("mem_release", Idle);
    chk("wait_cnt_cleared", 32'(dut.wait_cnt), 0);
    chk("state_run", 32'(dut.state), 32'(HzStateRun));
    set_in(5, 0, 5, 1, 0, 1, 0, 1, 0);
    lit("load_use_during_wait", MemStall);
    set_in(5, 0, 5, 1, 0, 1, 0, 1, 1);
    lit("load_use_on_release", LoadStall);
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 0);
    lit("branch_during_wait", MemStall);
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
    lit("branch_on_req_drop", Branch);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (T) lit("pre_timeout", MemStall);
    lit("timeout_halt", Halted);
    set_in(2, 2, 2, 1, 1, 1, 1, 0, 0);
    lit("halt_sticky", Halted);
    rst = 1'b0;
    lit("halt_until_edge", Halted);
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    lit("halt_cleared", Idle);
`ifdef HAZARD_PERF_CNT_EN
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    set_in(4, 0, 4, 1, 0, 1, 0, 0, 0);
    lit("perf_lu1", LoadStall);
    set_in(0, 9, 9, 0, 1, 1, 0, 0, 0);
    lit("perf_lu2", LoadStall);
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
    lit("perf_br", Branch);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (3) lit("perf_wait", MemStall);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
    lit("perf_release", Idle);
    chk("perf_load_count", perf_load_stalls, 2);
    chk("perf_mem_count", perf_mem_stalls, 3);
    chk("perf_flush_count", perf_flushes, 1);
`endif
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) != 0);
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 4) > 1);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
